// File: rtl/mult_share_arb_pkg.sv
// Shared defaults and elaboration-time helpers for the shared-multiplier arbiter.
package mult_share_arb_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_CYCLES = 2;
  localparam int DEF_NREQ   = 4;

  // Never returns less than 1 so single-entry indices still get a real bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mult_share_arb_multfix.sv
// Pipelined unsigned multiplier, CYCLES register stages, no stall input.
// q_unsc = low WIDTH bits of a*b; q_sc = a*b >> WIDTH/2 (fixed point), truncated to WIDTH.
module multfix
  import mult_share_arb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CYCLES = DEF_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q_sc,
  output logic [WIDTH-1:0] q_unsc
);

  localparam int FRAC = WIDTH / 2;
  localparam int PRW  = WIDTH + FRAC;

  // Bits above FRAC+WIDTH never reach an output, so the product is kept narrow.
  logic [PRW-1:0] prod;
  logic [PRW-1:0] pipe [CYCLES];

  assign prod = PRW'(a) * PRW'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CYCLES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= prod;
      for (int i = 1; i < CYCLES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q_unsc = pipe[CYCLES-1][WIDTH-1:0];
  assign q_sc   = pipe[CYCLES-1][FRAC +: WIDTH];

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin share of one pipelined multiplier among NREQ requesters; CYCLES+1 cycles issue-to-resp_valid.
// Issue is throttled so results in flight plus buffered never exceed the output FIFO depth.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CYCLES = DEF_CYCLES,
  parameter int NREQ   = DEF_NREQ,
  parameter int DEPTH  = CYCLES + 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [clog2(NREQ)-1:0]   resp_id,
  output logic [WIDTH-1:0]         resp_q_sc,
  output logic [WIDTH-1:0]         resp_q_unsc
);

  localparam int IDW = clog2(NREQ);
  localparam int IW1 = IDW + 1;
  localparam int PW  = clog2(DEPTH);
  localparam int CW  = clog2(DEPTH + 1);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic [IW1-1:0]   scan_idx;
  logic             grant_found;
  logic             can_issue;
  logic             xfer;
  logic             push;
  logic             pop;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    inflight;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             tag_vld [CYCLES];
  logic [IDW-1:0]   tag_id  [CYCLES];
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_q_sc;
  logic [WIDTH-1:0] mul_q_unsc;
  logic             mul_rst;
  logic [IDW-1:0]   mem_id   [DEPTH];
  logic [WIDTH-1:0] mem_sc   [DEPTH];
  logic [WIDTH-1:0] mem_unsc [DEPTH];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < CYCLES; i++) inflight = inflight + CW'(tag_vld[i]);
  end

  // Every result in flight has a reserved FIFO slot, so a push never meets a full FIFO.
  assign can_issue = (fifo_count + inflight) < CW'(DEPTH);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + IW1'(i);
      if (scan_idx >= IW1'(NREQ)) scan_idx = scan_idx - IW1'(NREQ);
      if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[IDW-1:0];
      end
    end
  end

  assign xfer = grant_found && can_issue && reset_n;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  assign mul_a   = xfer ? req_a[grant_idx*WIDTH +: WIDTH] : '0;
  assign mul_b   = xfer ? req_b[grant_idx*WIDTH +: WIDTH] : '0;
  assign mul_rst = ~reset_n;

  multfix #(
    .WIDTH  (WIDTH),
    .CYCLES (CYCLES)
  ) u_multfix (
    .clk    (clk),
    .rst    (mul_rst),
    .a      (mul_a),
    .b      (mul_b),
    .q_sc   (mul_q_sc),
    .q_unsc (mul_q_unsc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Tags ride alongside the multiplier stages so the last stage names the result's owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CYCLES; i++) begin
        tag_vld[i] <= 1'b0;
        tag_id[i]  <= '0;
      end
    end else begin
      tag_vld[0] <= xfer;
      tag_id[0]  <= grant_idx;
      for (int i = 1; i < CYCLES; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign push       = tag_vld[CYCLES-1];
  assign resp_valid = (fifo_count != '0);
  assign pop        = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= tag_id[CYCLES-1];
      mem_sc[wr_ptr]   <= mul_q_sc;
      mem_unsc[wr_ptr] <= mul_q_unsc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked whenever the FIFO is empty.
  assign resp_id     = resp_valid ? mem_id[rd_ptr]   : '0;
  assign resp_q_sc   = resp_valid ? mem_sc[rd_ptr]   : '0;
  assign resp_q_unsc = resp_valid ? mem_unsc[rd_ptr] : '0;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed and randomized checks of mult_share_arb against a queue-based reference model.
module tb_mult_share_arb;

  localparam int WIDTH  = 16;
  localparam int CYCLES = 2;
  localparam int NREQ   = 4;
  localparam int DEPTH  = CYCLES + 2;
  localparam int IDW    = 2;

  logic                  clk;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_q_sc;
  logic [WIDTH-1:0]      resp_q_unsc;

  int checks = 0;
  int errors = 0;

  mult_share_arb #(
    .WIDTH  (WIDTH),
    .CYCLES (CYCLES),
    .NREQ   (NREQ),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_q_sc   (resp_q_sc),
    .resp_q_unsc (resp_q_unsc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] prod_unsc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return p[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] prod_sc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [31:0] p;
    p = (32'(a) * 32'(b)) >> (WIDTH / 2);
    return p[WIDTH-1:0];
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Reference model: outstanding work is a queue in issue order; the head becomes
  // visible CYCLES edges after its issue edge, and issue is allowed while fewer
  // than DEPTH items are outstanding.
  typedef struct {
    int               id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               issued_at;
  } item_t;

  item_t mq[$];
  item_t m_item;
  int    rr_m     = 0;
  int    edge_cnt = 0;
  int    n_issued = 0;
  int    n_popped = 0;
  bit    m_xfer   = 1'b0;
  bit    m_pop    = 1'b0;

  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int g;
    int j;
    bit ev;
    er = '0;
    g  = -1;
    if (reset_n && mq.size() < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (rr_m + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(er));
    ev = reset_n && (mq.size() > 0) && (edge_cnt >= mq[0].issued_at + CYCLES);
    check("resp_valid", 32'(resp_valid), 32'(ev));
    if (ev) begin
      check("resp_id", 32'(resp_id), 32'(mq[0].id));
      check("resp_q_unsc", 32'(resp_q_unsc), 32'(prod_unsc(mq[0].a, mq[0].b)));
      check("resp_q_sc", 32'(resp_q_sc), 32'(prod_sc(mq[0].a, mq[0].b)));
    end else if (!reset_n) begin
      check("reset_resp_id", 32'(resp_id), 32'd0);
      check("reset_resp_q", 32'({resp_q_sc, resp_q_unsc}), 32'd0);
    end
    m_xfer = (g >= 0);
    if (m_xfer) begin
      m_item.id = g;
      m_item.a  = req_a[g*WIDTH +: WIDTH];
      m_item.b  = req_b[g*WIDTH +: WIDTH];
    end
    m_pop = ev && resp_ready;
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      rr_m     = 0;
      n_issued = 0;
      n_popped = 0;
    end else begin
      edge_cnt++;
      if (m_pop) begin
        void'(mq.pop_front());
        n_popped++;
      end
      if (m_xfer) begin
        m_item.issued_at = edge_cnt;
        mq.push_back(m_item);
        n_issued++;
        rr_m = (m_item.id + 1) % NREQ;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int cnt;
    bit found;
    int gseq[$];
    int rseq[$];

    // Reset state: outputs quiet even with every requester asking.
    reset_n    = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b1;
    req_a      = '0;
    req_b      = '0;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_fields", 32'({resp_id, resp_q_sc, resp_q_unsc}), 32'd0);
    reset_n   = 1'b1;
    req_valid = '0;
    tick();

    // Single request from requester 2: 2*3.
    rand_ops();
    req_a[2*WIDTH +: WIDTH] = 16'h0002;
    req_b[2*WIDTH +: WIDTH] = 16'h0003;
    req_valid = 4'b0100;
    @(negedge clk);
    check("single_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    found = 1'b0;
    n = 0;
    for (int w = 1; w <= 10 && !found; w++) begin
      @(negedge clk);
      if (resp_valid) begin
        found = 1'b1;
        n = w;
      end else begin
        @(posedge clk);
      end
    end
    check("single_latency", 32'(n), 32'd3);
    check("single_id", 32'(resp_id), 32'd2);
    check("single_unsc", 32'(resp_q_unsc), 32'h6);
    check("single_sc", 32'(resp_q_sc), 32'h0);
    tick();

    // All requesters valid, consumer always ready: round-robin at full rate.
    do_reset();
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      rand_ops();
      @(negedge clk);
      if (|(req_valid & req_ready)) gseq.push_back(onehot_idx(req_ready));
      if (resp_valid) rseq.push_back(int'(resp_id));
      tick();
    end
    req_valid = '0;
    check("rr_grant_count", 32'(gseq.size()), 32'd14);
    check("rr_resp_count", 32'(rseq.size()), 32'd11);
    for (int k = 0; k < 8 && k < gseq.size(); k++) check("rr_grant_seq", 32'(gseq[k]), 32'(k % 4));
    for (int k = 0; k < 8 && k < rseq.size(); k++) check("rr_resp_seq", 32'(rseq[k]), 32'(k % 4));
    repeat (5) tick();

    // Consumer stalled: exactly DEPTH issues, then drain and resume.
    req_valid  = '1;
    resp_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      rand_ops();
      @(negedge clk);
      if (|(req_valid & req_ready)) cnt++;
      tick();
    end
    check("stall_issue_count", 32'(cnt), 32'(DEPTH));
    @(negedge clk);
    check("stall_ready_low", 32'(req_ready), 32'd0);
    tick();
    req_valid  = '0;
    resp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) cnt++;
      tick();
    end
    check("stall_drain_count", 32'(cnt), 32'(DEPTH));
    req_valid = '1;
    @(negedge clk);
    check("stall_resume", 32'(req_ready != '0), 32'd1);
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Push and pop on the same edge with three results buffered.
    resp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      rand_ops();
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
    end
    repeat (3) tick();
    check("pp_count_before", 32'(dut.fifo_count), 32'd3);
    rand_ops();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("pp_count_after", 32'(dut.fifo_count), 32'd3);
    resp_ready = 1'b1;
    repeat (6) tick();

    // Reset with two buffered and two in flight; rr pointer left at 1 beforehand.
    resp_ready = 1'b0;
    rand_ops();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (3) tick();
    req_valid = '1;
    rand_ops();
    tick();
    tick();
    check("midrst_buffered", 32'(dut.fifo_count), 32'd2);
    reset_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_resp_fields", 32'({resp_id, resp_q_sc, resp_q_unsc}), 32'd0);
    req_valid = '0;
    tick();
    tick();
    reset_n    = 1'b1;
    resp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
      tick();
    end
    check("midrst_no_stale", 32'(cnt), 32'd0);
    req_valid = '1;
    @(negedge clk);
    check("midrst_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 9) < 7);
      rand_ops();
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (10) tick();
    check("final_outstanding", 32'(mq.size()), 32'd0);
    check("final_resp_valid", 32'(resp_valid), 32'd0);
    check("issued_vs_returned", 32'(n_popped), 32'(n_issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
